alu_issue_ctrl: RTL and testbench

- Initiator side of the 8-bit ALU interface.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file.
- Drives the combinational ALU's a/b/opcode/cin inputs for one cycle, then writes the ALU result into the register file and the ALU flags into a flags register.
- Sits between the instruction decoder and the ALU in the CPU datapath.

---
 rtl/alu_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Initiator side of the 8-bit ALU interface. Accepts one instruction at a time
// over a valid/ready handshake, reads its operands from an internal register
// file, presents them to a combinational ALU for one cycle, then writes the
// ALU result back into the register file and the ALU flags into a flags
// register. Sequence per instruction: IDLE -> ISSUE -> DONE -> IDLE.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   instr_valid/ready       instruction handshake
//   instr_op                ALU opcode (0..9 legal, 10..15 illegal)
//   instr_rd                destination register and A-operand source
//   instr_rs                B-operand source register
//   instr_imm_en, instr_imm select immediate B operand
//   instr_use_carry         feed stored C flag into alu_cin (ADC/SBC style)
//   alu_a/b/opcode/cin      ALU inputs, non-zero only during ISSUE
//   alu_result, alu_*flags  ALU outputs, sampled on the edge leaving ISSUE
//   flags                   stored flags {Z,C,V,N}
//   done, err               one-cycle retire pulse; err flags an illegal opcode
//   dbg_addr, dbg_data      combinational register-file read port
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [3:0]                  instr_op,
    input  logic [$clog2(NUM_REGS)-1:0] instr_rd,
    input  logic [$clog2(NUM_REGS)-1:0] instr_rs,
    input  logic                        instr_imm_en,
    input  logic [DATA_W-1:0]           instr_imm,
    input  logic                        instr_use_carry,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic [3:0]                  alu_opcode,
    output logic                        alu_cin,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic                        alu_zero,
    input  logic                        alu_carry,
    input  logic                        alu_overflow,
    input  logic                        alu_negative,
    output logic [3:0]                  flags,
    output logic                        done,
    output logic                        err,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]           dbg_data
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic [3:0]          op_q;
    logic [IDX_W-1:0]    rd_q;
    logic [IDX_W-1:0]    rs_q;
    logic                imm_en_q;
    logic [DATA_W-1:0]   imm_q;
    logic                use_carry_q;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [3:0]          flags_q, flags_d;

    logic                accept;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= 4'd9);
    endfunction

    assign accept = (state_q == S_IDLE) && instr_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Instruction fields are only observed while the FSM is out of IDLE, and
    // all outputs derived from them are gated by state, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q        <= instr_op;
            rd_q        <= instr_rd;
            rs_q        <= instr_rs;
            imm_en_q    <= instr_imm_en;
            imm_q       <= instr_imm;
            use_carry_q <= instr_use_carry;
        end
    end

    // Writeback happens on the edge leaving ISSUE; illegal opcodes retire
    // without touching architectural state.
    always_comb begin
        regs_d  = regs_q;
        flags_d = flags_q;
        if ((state_q == S_ISSUE) && is_legal_op(op_q)) begin
            regs_d[rd_q] = alu_result;
            flags_d      = {alu_zero, alu_carry, alu_overflow, alu_negative};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= 4'b0000;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    // Output logic
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        alu_a       = '0;
        alu_b       = '0;
        alu_opcode  = 4'b0000;
        alu_cin     = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            S_ISSUE: begin
                // Operands read the register file live, so the previous
                // instruction's writeback is already visible here.
                alu_a      = regs_q[rd_q];
                alu_b      = imm_en_q ? imm_q : regs_q[rs_q];
                alu_opcode = op_q;
                alu_cin    = use_carry_q & flags_q[2];
            end
            S_DONE: begin
                done = 1'b1;
                err  = !is_legal_op(op_q);
            end
            default: ;
        endcase
    end

    assign flags    = flags_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic       instr_imm_en;
    logic [7:0] instr_imm;
    logic       instr_use_carry;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic       alu_cin;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_negative;
    logic [3:0] flags;
    logic       done;
    logic       err;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    // Debug read port is shared: the monitor owns it while checking a retire,
    // the stimulus borrows it for directed reads while the DUT is idle.
    logic [1:0] dbg_stim   = 2'd0;
    logic [1:0] dbg_mon    = 2'd0;
    logic       dbg_by_mon = 1'b0;
    assign dbg_addr = dbg_by_mon ? dbg_mon : dbg_stim;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NUM_REGS(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .instr_use_carry(instr_use_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_negative(alu_negative),
        .flags(flags), .done(done), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: returns {result, Z, C, V, N}. SUB reports borrow in C.
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op, input logic cin);
        int u, s;
        logic [7:0] res;
        logic c, v;
        u = 0; s = 0; c = 1'b0; v = 1'b0; res = 8'h00;
        case (op)
            4'd0: begin
                u = int'(a) + int'(b) + int'(cin);
                s = int'($signed(a)) + int'($signed(b)) + int'(cin);
                res = 8'(u); c = (u > 255); v = (s > 127) || (s < -128);
            end
            4'd1: begin
                u = int'(a) - int'(b) - int'(cin);
                s = int'($signed(a)) - int'($signed(b)) - int'(cin);
                res = 8'(u); c = (u < 0); v = (s > 127) || (s < -128);
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ~a;
            4'd6: res = ((a != 0) && (b != 0)) ? 8'h01 : 8'h00;
            4'd7: res = ((a != 0) || (b != 0)) ? 8'h01 : 8'h00;
            4'd8: res = ((a != 0) != (b != 0)) ? 8'h01 : 8'h00;
            4'd9: res = (a == 0) ? 8'h01 : 8'h00;
            default: res = 8'h00;
        endcase
        return {res, (res == 8'h00), c, v, res[7]};
    endfunction

    always_comb begin
        {alu_result, alu_zero, alu_carry, alu_overflow, alu_negative} =
            alu_ref(alu_a, alu_b, alu_opcode, alu_cin);
    end

    typedef struct {
        logic [1:0] rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       cin;
        logic       err;
        logic [7:0] rdval;
        logic [3:0] flg;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mreg [4];
    logic [3:0] mflg;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mflg = 4'b0000;
    endtask

    // Reference: architectural effect of one accepted instruction.
    task automatic predict(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                           input logic ie, input logic [7:0] imm, input logic uc);
        exp_t e;
        logic [11:0] r;
        e.rd  = rd;
        e.a   = mreg[rd];
        e.b   = ie ? imm : mreg[rs];
        e.op  = op;
        e.cin = uc & mflg[2];
        e.err = (op > 4'd9);
        r = alu_ref(e.a, e.b, op, e.cin);
        if (!e.err) begin
            mreg[rd] = r[11:4];
            mflg     = r[3:0];
        end
        e.rdval = mreg[rd];
        e.flg   = mflg;
        exp_q.push_back(e);
    endtask

    task automatic junk_fields();
        instr_op        = 4'($urandom_range(0, 15));
        instr_rd        = 2'($urandom);
        instr_rs        = 2'($urandom);
        instr_imm_en    = 1'($urandom);
        instr_imm       = 8'($urandom);
        instr_use_carry = 1'($urandom);
    endtask

    // Returns at posedge+1 of the ISSUE cycle.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic ie, input logic [7:0] imm, input logic uc);
        int n;
        @(posedge clk); #1;
        instr_op = op; instr_rd = rd; instr_rs = rs;
        instr_imm_en = ie; instr_imm = imm; instr_use_carry = uc;
        instr_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 20);
        if (!instr_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ready=%0b after %0d cycles, expected 1", instr_ready, n);
            instr_valid = 1'b0;
            return;
        end
        predict(op, rd, rs, ie, imm, uc);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        junk_fields();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 20);
        if (!instr_ready) begin
            checks++; errors++;
            $display("FAIL idle_timeout: ready=%0b after %0d cycles, expected 1", instr_ready, n);
        end
    endtask

    task automatic peek(input string name, input logic [1:0] idx, input logic [7:0] exp);
        dbg_by_mon = 1'b0;
        dbg_stim   = idx;
        #1;
        chk(name, 32'(dbg_data), 32'(exp));
        dbg_by_mon = 1'b1;
    endtask

    // Monitor: tracks the handshake and checks each retire against the queue.
    initial begin : monitor
        int   pend;
        exp_t e;
        pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
            end else begin
                case (pend)
                    0: begin
                        chk("idle_done", 32'(done), 32'd0);
                        chk("idle_alu", 32'({alu_a, alu_b, alu_opcode, alu_cin}), 32'd0);
                        if (instr_valid && instr_ready) pend = 1;
                    end
                    1: begin
                        chk("issue_ready", 32'(instr_ready), 32'd0);
                        chk("issue_done", 32'(done), 32'd0);
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL sb_empty: ISSUE with no expected entry");
                        end else begin
                            e = exp_q[0];
                            chk("alu_a", 32'(alu_a), 32'(e.a));
                            chk("alu_b", 32'(alu_b), 32'(e.b));
                            chk("alu_opcode", 32'(alu_opcode), 32'(e.op));
                            chk("alu_cin", 32'(alu_cin), 32'(e.cin));
                            dbg_mon = e.rd;
                        end
                        pend = 2;
                    end
                    default: begin
                        chk("done_pulse", 32'(done), 32'd1);
                        chk("done_ready", 32'(instr_ready), 32'd0);
                        chk("done_alu", 32'({alu_a, alu_b, alu_opcode, alu_cin}), 32'd0);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("err", 32'(err), 32'(e.err));
                            chk("flags", 32'(flags), 32'(e.flg));
                            chk("rd_value", 32'(dbg_data), 32'(e.rdval));
                        end
                        pend = 0;
                    end
                endcase
            end
        end
    end

    initial begin : stimulus
        int acc_cyc [4];
        int nacc;
        int ndone;
        logic acc;

        rst_n = 1'b0;
        instr_valid = 1'b0;
        junk_fields();
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_opcode, alu_cin}), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        for (int i = 0; i < 4; i++) peek("rst_reg", 2'(i), 8'h00);
        dbg_by_mon = 1'b1;

        // Signed overflow
        issue(4'd0, 2'd1, 2'd0, 1'b1, 8'h7F, 1'b0);
        issue(4'd0, 2'd1, 2'd0, 1'b1, 8'h01, 1'b0);
        wait_idle();
        peek("ovf_r1", 2'd1, 8'h80);
        chk("ovf_flags", 32'(flags), 32'b0011);

        // Carry chain into ADC
        issue(4'd3, 2'd2, 2'd0, 1'b1, 8'h01, 1'b0);
        issue(4'd0, 2'd2, 2'd0, 1'b1, 8'hFF, 1'b0);
        wait_idle();
        peek("carry_r2", 2'd2, 8'h00);
        chk("carry_flags", 32'(flags), 32'b1100);
        issue(4'd0, 2'd3, 2'd0, 1'b1, 8'h00, 1'b1);
        chk("adc_cin", 32'(alu_cin), 32'd1);
        wait_idle();
        peek("adc_r3", 2'd3, 8'h01);
        chk("adc_flags", 32'(flags), 32'b0000);

        // Register-register SUB
        issue(4'd2, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0);
        issue(4'd3, 2'd0, 2'd0, 1'b1, 8'h05, 1'b0);
        issue(4'd2, 2'd1, 2'd0, 1'b1, 8'h00, 1'b0);
        issue(4'd3, 2'd1, 2'd0, 1'b1, 8'h03, 1'b0);
        issue(4'd1, 2'd0, 2'd1, 1'b0, 8'hAA, 1'b0);
        chk("sub_a", 32'(alu_a), 32'h05);
        chk("sub_b", 32'(alu_b), 32'h03);
        wait_idle();
        peek("sub_r0", 2'd0, 8'h02);
        chk("sub_flags", 32'(flags), 32'b0000);

        // Illegal opcode, then a legal one
        issue(4'b1100, 2'd0, 2'd1, 1'b1, 8'h5A, 1'b0);
        wait_idle();
        peek("illegal_r0", 2'd0, 8'h02);
        chk("illegal_flags", 32'(flags), 32'b0000);
        issue(4'd0, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0);
        wait_idle();
        peek("after_illegal_r0", 2'd0, 8'h03);

        // Back-to-back: valid held for 9 cycles
        @(posedge clk); #1;
        instr_valid = 1'b1;
        junk_fields();
        instr_op = 4'($urandom_range(0, 9));
        nacc = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            acc = instr_ready;
            if (acc) begin
                predict(instr_op, instr_rd, instr_rs, instr_imm_en, instr_imm, instr_use_carry);
                if (nacc < 4) acc_cyc[nacc] = c;
                nacc++;
            end
            @(posedge clk); #1;
            if (acc) begin
                junk_fields();
                instr_op = 4'($urandom_range(0, 9));
            end
        end
        instr_valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd3);
        if (nacc >= 3) begin
            chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        wait_idle();

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
                  2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        end
        wait_idle();

        // Make R1 non-zero so the abort check is meaningful
        issue(4'd3, 2'd1, 2'd0, 1'b1, 8'h40, 1'b0);
        wait_idle();

        // Reset during ISSUE
        issue(4'd0, 2'd1, 2'd0, 1'b1, 8'h10, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready_async", 32'(instr_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        model_reset();
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_flags", 32'(flags), 32'd0);
        peek("abort_r1", 2'd1, 8'h00);

        // Normal operation after abort
        issue(4'd4, 2'd2, 2'd0, 1'b1, 8'h3C, 1'b0);
        wait_idle();
        peek("post_abort_r2", 2'd2, 8'h3C);

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
